fetch_unit: RTL

- Instruction fetch stage of the RV32I core.
- Holds the PC and requests instructions from instruction memory over a valid/ready handshake.
- Registers the returned word as Instr, which feeds the decoder and the immediate extender.
- Takes the extended immediate (immExt) and the ALU result back to form branch, JAL and JALR targets.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32I fetch stage: PC, valid/ready imem request, registered Instr,
//            next-PC selection for sequential, branch, JAL and JALR targets.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] immExt,
    input  logic [31:0] alu_result,
    output logic        misaligned
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        req_valid_q, req_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] w_next_pc;

    always_comb begin
        case (PCSrc)
            2'b01:   w_next_pc = pc_q + immExt;
            2'b10:   w_next_pc = alu_result & ~32'h0000_0001;
            default: w_next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        req_valid_d   = req_valid_q;
        misaligned_d  = misaligned_q;
        case (state_q)
            S_FETCH: begin
                // req_valid is registered, so the first FETCH cycle after reset raises it
                if (req_valid_q && imem_req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d       = S_HOLD;
                    instr_d       = imem_rsp_data;
                    instr_valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d          = w_next_pc;
                    instr_valid_d = 1'b0;
                    if (w_next_pc[1:0] == 2'b00) begin
                        state_d     = S_FETCH;
                        req_valid_d = 1'b1;
                    end else begin
                        state_d      = S_TRAP;
                        misaligned_d = 1'b1;
                    end
                end
            end
            default: begin
                req_valid_d   = 1'b0;
                instr_valid_d = 1'b0;
                misaligned_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= c_NOP;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            req_valid_q   <= req_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_q + 32'd4;
    assign instr_valid    = instr_valid_q;
    assign misaligned     = misaligned_q;

endmodule
`default_nettype wire
